writeback_stage: RTL and testbench

MEM/WB pipeline stage that sits directly upstream of the register file. It accepts one retiring instruction per cycle from the memory stage and waits for variable-latency load data when needed. It aligns and extends load data, selects the writeback value and presents insn/control/rt/rd/data to the register file for exactly one commit cycle. It also exports the committing destination and data for forwarding.

---
 rtl/writeback_stage.sv | 166 ++++++++++++++++
 tb/tb_writeback_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB stage: holds one retiring instruction, waits for load data when needed,
// and presents a single-cycle commit to the register file plus a forwarding entry.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter int CNT_W    = 16,
    parameter int RWE_BIT  = 0,
    parameter int RDST_BIT = 1,
    parameter int RA_BIT   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [31:0]       m_insn,
    input  logic [CTRL_W-1:0] m_control,
    input  logic [DATA_W-1:0] m_alu_result,
    input  logic [31:0]       m_pc,
    input  logic              m_is_load,
    input  logic              m_is_link,
    input  logic [1:0]        m_load_size,
    input  logic              m_load_signed,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_rvalid,
    output logic [31:0]       wb_insn,
    output logic [CTRL_W-1:0] wb_control,
    output logic [4:0]        wb_rt,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [4:0]        fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  load_wait_cnt
);

    typedef enum logic [1:0] {EMPTY, WAIT_MEM, COMMIT} state_t;

    state_t              state, state_next;
    logic                accept;
    logic [31:0]         e_insn;
    logic [CTRL_W-1:0]   e_control;
    logic [DATA_W-1:0]   e_alu;
    logic [31:0]         e_pc;
    logic                e_is_load, e_is_link, e_signed;
    logic [1:0]          e_size;
    logic [DATA_W-1:0]   load_data;
    logic                misaligned;
    logic [4:0]          dest;
    logic                we_gated;
    logic [DATA_W-1:0]   result;

    // Big-endian lane selection: offset 0 is the most significant byte.
    function automatic logic [DATA_W-1:0] align_load(input logic [31:0] word,
                                                     input logic [1:0]  off,
                                                     input logic [1:0]  size,
                                                     input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   align_load = {{(DATA_W-8){sgn & b[7]}}, b};
            2'b01:   align_load = {{(DATA_W-16){sgn & h[15]}}, h};
            default: align_load = DATA_W'(word);
        endcase
    endfunction

    assign m_ready = (state == EMPTY) || (state == COMMIT);
    assign accept  = m_valid && m_ready;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:    if (accept) state_next = m_is_load ? WAIT_MEM : COMMIT;
            WAIT_MEM: if (dmem_rvalid) state_next = COMMIT;
            COMMIT:   if (accept) state_next = m_is_load ? WAIT_MEM : COMMIT;
                      else        state_next = EMPTY;
            default:  state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= EMPTY;
            e_insn        <= '0;
            e_control     <= '0;
            e_alu         <= '0;
            e_pc          <= '0;
            e_is_load     <= 1'b0;
            e_is_link     <= 1'b0;
            e_size        <= 2'b00;
            e_signed      <= 1'b0;
            load_data     <= '0;
            load_wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                e_insn    <= m_insn;
                e_control <= m_control;
                e_alu     <= m_alu_result;
                e_pc      <= m_pc;
                e_is_load <= m_is_load;
                e_is_link <= m_is_link;
                e_size    <= m_load_size;
                e_signed  <= m_load_signed;
            end
            if (state == WAIT_MEM) begin
                if (dmem_rvalid)
                    load_data <= align_load(dmem_rdata, e_alu[1:0], e_size, e_signed);
                else if (load_wait_cnt != {CNT_W{1'b1}})
                    load_wait_cnt <= load_wait_cnt + 1'b1;
            end
        end
    end

    // Size 11 is treated as a word, so size[1] covers both word encodings.
    assign misaligned = e_is_load &&
                        (((e_size == 2'b01) && e_alu[0]) ||
                         (e_size[1] && (e_alu[1:0] != 2'b00)));

    always_comb begin
        dest = e_insn[20:16];
        if (e_control[RDST_BIT] && e_control[RA_BIT])
            dest = 5'd31;
        else if (e_control[RDST_BIT])
            dest = e_insn[15:11];
    end

    assign we_gated = e_control[RWE_BIT] && (dest != 5'd0) && !misaligned;
    assign result   = e_is_link ? DATA_W'(e_pc + 32'd8) :
                      e_is_load ? load_data : e_alu;

    // NOTE: every output gets a default before the branch, so no latch is inferred.
    always_comb begin
        wb_insn      = '0;
        wb_control   = '0;
        wb_rt        = '0;
        wb_rd        = '0;
        wb_data      = '0;
        fwd_valid    = 1'b0;
        fwd_reg      = '0;
        fwd_data     = '0;
        misalign_err = 1'b0;
        if (state == COMMIT) begin
            wb_insn             = e_insn;
            wb_control          = e_control;
            wb_control[RWE_BIT] = we_gated;
            wb_rt               = e_insn[20:16];
            wb_rd               = e_insn[15:11];
            wb_data             = result;
            fwd_valid           = we_gated;
            fwd_reg             = dest;
            fwd_data            = result;
            misalign_err        = misaligned;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver queues expected commits,
// a negedge monitor pops and compares whenever the stage presents a commit.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_insn;
    logic [7:0]  m_control;
    logic [31:0] m_alu_result;
    logic [31:0] m_pc;
    logic        m_is_load, m_is_link, m_load_signed;
    logic [1:0]  m_load_size;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [31:0] wb_insn;
    logic [7:0]  wb_control;
    logic [4:0]  wb_rt, wb_rd;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        misalign_err;
    logic [15:0] load_wait_cnt;

    writeback_stage dut (
        .clock(clock), .reset_n(reset_n),
        .m_valid(m_valid), .m_ready(m_ready), .m_insn(m_insn), .m_control(m_control),
        .m_alu_result(m_alu_result), .m_pc(m_pc), .m_is_load(m_is_load),
        .m_is_link(m_is_link), .m_load_size(m_load_size), .m_load_signed(m_load_signed),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .wb_insn(wb_insn), .wb_control(wb_control), .wb_rt(wb_rt), .wb_rd(wb_rd),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .misalign_err(misalign_err), .load_wait_cnt(load_wait_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] insn;
        logic [7:0]  ctrl;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fv;
        logic [4:0]  freg;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void push_exp(input logic [31:0] insn, input logic [7:0] ctrl,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [31:0] data, input logic fv,
                                     input logic [4:0] freg, input logic mis, input int c);
        exp_t e;
        e.insn = insn; e.ctrl = ctrl; e.rt = rt; e.rd = rd; e.data = data;
        e.fv = fv; e.freg = freg; e.mis = mis; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    // Monitor: a nonzero wb_insn marks a commit cycle (every test instruction is nonzero).
    always @(negedge clock) begin
        if (reset_n) begin
            if (wb_insn != 32'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", wb_insn, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_cycle", cyc, mon_e.cyc);
                    check("wb_insn", wb_insn, mon_e.insn);
                    check("wb_control", {24'd0, wb_control}, {24'd0, mon_e.ctrl});
                    check("wb_rt", {27'd0, wb_rt}, {27'd0, mon_e.rt});
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                    check("wb_data", wb_data, mon_e.data);
                    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, mon_e.fv});
                    check("misalign_err", {31'd0, misalign_err}, {31'd0, mon_e.mis});
                    if (mon_e.fv) begin
                        check("fwd_reg", {27'd0, fwd_reg}, {27'd0, mon_e.freg});
                        check("fwd_data", fwd_data, mon_e.data);
                    end
                end
            end else begin
                check("idle_quiet", {23'd0, misalign_err, fwd_valid, wb_control}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] insn, input logic [7:0] ctrl,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic ld, input logic lk,
                           input logic [1:0] sz, input logic sg);
        m_valid = 1'b1; m_insn = insn; m_control = ctrl; m_alu_result = alu;
        m_pc = pc; m_is_load = ld; m_is_link = lk; m_load_size = sz; m_load_signed = sg;
    endtask

    task automatic drop_valid();
        m_valid = 1'b0; m_insn = '0; m_control = '0; m_is_load = 1'b0; m_is_link = 1'b0;
    endtask

    // Load returning data one cycle after accept; rt destination, small immediate so rd=0.
    task automatic do_load(input logic [4:0] rt, input logic [31:0] alu,
                           input logic [1:0] sz, input logic sg, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input logic [7:0] exp_ctrl,
                           input logic exp_mis);
        logic [31:0] insn;
        insn = {6'h23, 5'd1, rt, 4'd0, alu[11:0]};
        present(insn, 8'h01, alu, 32'h0040_0100, 1'b1, 1'b0, sz, sg);
        step();
        drop_valid();
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        push_exp(insn, exp_ctrl, rt, 5'd0, exp_data, exp_ctrl[0], rt, exp_mis, cyc + 1);
        step();
        dmem_rvalid = 1'b0;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        m_valid = 1'b0; m_insn = '0; m_control = '0; m_alu_result = '0; m_pc = '0;
        m_is_load = 1'b0; m_is_link = 1'b0; m_load_size = 2'b00; m_load_signed = 1'b0;
        dmem_rdata = '0; dmem_rvalid = 1'b0;

        #2;
        check("reset_m_ready", {31'd0, m_ready}, 32'd1);
        check("reset_wb_control", {24'd0, wb_control}, 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("reset_wait_cnt", {16'd0, load_wait_cnt}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Back-to-back non-loads: addu rd=8, then ori rt=9.
        present(32'h0022_4021, 8'h03, 32'd5, 32'h0040_0000, 1'b0, 1'b0, 2'b10, 1'b0);
        push_exp(32'h0022_4021, 8'h03, 5'd2, 5'd8, 32'd5, 1'b1, 5'd8, 1'b0, cyc + 1);
        check("t1_ready_a", {31'd0, m_ready}, 32'd1);
        step();
        present(32'h3409_00FF, 8'h01, 32'h0000_00FF, 32'h0040_0004, 1'b0, 1'b0, 2'b10, 1'b0);
        push_exp(32'h3409_00FF, 8'h01, 5'd9, 5'd0, 32'h0000_00FF, 1'b1, 5'd9, 1'b0, cyc + 1);
        check("t1_ready_b", {31'd0, m_ready}, 32'd1);
        step();
        drop_valid();
        check("t1_ready_c", {31'd0, m_ready}, 32'd1);
        step(); step();

        // lb signed at offset 1, rvalid 3 cycles after accept; a stray rvalid in the accept cycle is ignored.
        present(32'h802A_0001, 8'h01, 32'h0000_1001, 32'h0040_0008, 1'b1, 1'b0, 2'b00, 1'b1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        drop_valid();
        dmem_rvalid = 1'b0;
        check("t2_ready_w1", {31'd0, m_ready}, 32'd0);
        step();
        check("t2_ready_w2", {31'd0, m_ready}, 32'd0);
        step();
        check("t2_ready_w3", {31'd0, m_ready}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1280_3456;
        push_exp(32'h802A_0001, 8'h01, 5'd10, 5'd0, 32'hFFFF_FF80, 1'b1, 5'd10, 1'b0, cyc + 1);
        step();
        dmem_rvalid = 1'b0;
        check("t2_wait_cnt", {16'd0, load_wait_cnt}, 32'd2);
        check("t2_ready_commit", {31'd0, m_ready}, 32'd1);
        step();

        // jal with RA: link value pc+8 into r31.
        present(32'h0C10_0004, 8'h07, 32'h0000_AAAA, 32'h0040_0010, 1'b0, 1'b1, 2'b10, 1'b0);
        push_exp(32'h0C10_0004, 8'h07, 5'd16, 5'd0, 32'h0040_0018, 1'b1, 5'd31, 1'b0, cyc + 1);
        step();
        drop_valid();
        step();

        // Write to $0 is suppressed.
        present(32'h0022_0021, 8'h03, 32'h0000_1234, 32'h0040_0014, 1'b0, 1'b0, 2'b10, 1'b0);
        push_exp(32'h0022_0021, 8'h02, 5'd2, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0, cyc + 1);
        step();
        drop_valid();
        step();

        // Sub-word alignment and extension.
        do_load(5'd12, 32'h0000_2000, 2'b01, 1'b1, 32'h8001_7FFF, 32'hFFFF_8001, 8'h01, 1'b0);
        do_load(5'd13, 32'h0000_2002, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0000_ABCD, 8'h01, 1'b0);
        do_load(5'd14, 32'h0000_2003, 2'b00, 1'b0, 32'h0000_00F0, 32'h0000_00F0, 8'h01, 1'b0);
        do_load(5'd15, 32'h0000_2000, 2'b00, 1'b1, 32'h7FAA_0000, 32'h0000_007F, 8'h01, 1'b0);

        // Misaligned lw: error pulse, no write, data still driven, then EMPTY.
        do_load(5'd11, 32'h0000_2002, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00, 1'b1);
        check("t5_ready_empty", {31'd0, m_ready}, 32'd1);
        check("t5_control_empty", {24'd0, wb_control}, 32'd0);
        check("t5_wait_cnt", {16'd0, load_wait_cnt}, 32'd2);

        // Reset during WAIT_MEM discards the entry; late rvalid is ignored.
        present(32'h8C05_0000, 8'h01, 32'h0000_3000, 32'h0040_0200, 1'b1, 1'b0, 2'b10, 1'b0);
        step();
        drop_valid();
        step();
        check("t6_wait_cnt_pre", {16'd0, load_wait_cnt}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_ready_in_reset", {31'd0, m_ready}, 32'd1);
        check("t6_cnt_in_reset", {16'd0, load_wait_cnt}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        step();
        dmem_rvalid = 1'b0;
        check("t6_ready_after", {31'd0, m_ready}, 32'd1);
        check("t6_wb_insn_after", wb_insn, 32'd0);
        check("t6_wb_data_after", wb_data, 32'd0);
        check("t6_fwd_valid_after", {31'd0, fwd_valid}, 32'd0);
        check("t6_cnt_after", {16'd0, load_wait_cnt}, 32'd0);
        step(); step();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
